block_collider: RTL and testbench

Ball-versus-brick collision engine that sits directly upstream of `block_memory` on its game-logic port (`row1`/`col1`/`func`/`enable`, returning `block1`/`ready`). For each request from `state_control` it probes the brick cells at the ball's leading edges, reads each cell, and damages any occupied cell. It returns per-axis bounce flags and a score increment. One request is handled at a time; the block is idle between frames.

---
 rtl/block_collider_if.sv | 27 ++
 rtl/block_collider.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_block_collider.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/block_collider_if.sv
// block_collider_if
// Game-logic port between block_collider and block_memory.
//   bm_enable : memory request, held until bm_ready is seen
//   bm_row    : brick row address (5 bits)
//   bm_col    : brick column address (5 bits)
//   bm_func   : 2'b00 read, 2'b01 hit (decrement strength)
//   bm_block  : strength of the addressed cell, 0 = empty
//   bm_ready  : memory finished the current request
// Modports: master = collider side, slave = memory side.
interface block_collider_if;
   logic       bm_enable;
   logic [4:0] bm_row;
   logic [4:0] bm_col;
   logic [1:0] bm_func;
   logic [3:0] bm_block;
   logic       bm_ready;

   modport master (
      output bm_enable, bm_row, bm_col, bm_func,
      input  bm_block, bm_ready
   );

   modport slave (
      input  bm_enable, bm_row, bm_col, bm_func,
      output bm_block, bm_ready
   );
endinterface

// File: rtl/block_collider.sv
// block_collider
// Ball-versus-brick collision engine. For each request it probes the brick
// cells under the ball's leading edges, reads each cell through block_memory
// and issues a hit to any occupied cell, then reports per-axis bounce flags
// and the number of bricks hit.
//
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   req                : start pulse, only honoured while idle
//   ball_x, ball_y     : ball centre (10 bits each)
//   radius             : ball radius (6 bits)
//   dx_neg, dy_neg     : ball moving left / up
//   bm                 : block_collider_if.master, memory port
//   busy               : high from request acceptance until done
//   done               : one-cycle completion pulse
//   flip_x, flip_y     : bounce results, held until the next request
//   score_inc          : bricks hit by this request
//   timeout_err        : sticky memory-timeout flag, cleared by reset
//
// Optional feature: define BLOCK_COLLIDER_CORNER_EN to add a third, diagonal
// probe that runs only when both axis probes missed; a hit there flips both
// axes.
module block_collider #(
   parameter int FIELD_TOP    = 40,
   parameter int BLOCK_W_LOG2 = 5,
   parameter int BLOCK_H_LOG2 = 4,
   parameter int ROWS         = 12,
   parameter int COLS         = 20,
   parameter int TIMEOUT      = 255
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req,
   input  logic [9:0]              ball_x,
   input  logic [9:0]              ball_y,
   input  logic [5:0]              radius,
   input  logic                    dx_neg,
   input  logic                    dy_neg,
   block_collider_if.master        bm,
   output logic                    busy,
   output logic                    done,
   output logic                    flip_x,
   output logic                    flip_y,
   output logic [1:0]              score_inc,
   output logic                    timeout_err
);

   typedef enum logic [2:0] {
      IDLE,
      CALC,
      READ,
      EVAL,
      WRITE,
      DONE
   } state_t;

   localparam int WaitW = $clog2(TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
   localparam logic signed [10:0] FieldTop = 11'(FIELD_TOP);
   localparam logic [10:0] RowLimit = 11'(ROWS);
   localparam logic [10:0] ColLimit = 11'(COLS);
   localparam logic [1:0] FuncRead = 2'b00;
   localparam logic [1:0] FuncHit  = 2'b01;

`ifdef BLOCK_COLLIDER_CORNER_EN
   localparam bit CornerEn = 1'b1;
`else
   localparam bit CornerEn = 1'b0;
`endif

   state_t           state_q, state_d;
   logic [1:0]       probe_q, probe_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [5:0]       r_q, r_d;
   logic             dxn_q, dxn_d;
   logic             dyn_q, dyn_d;
   logic [3:0]       blk_q, blk_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic             enable_q, enable_d;
   logic [4:0]       row_q, row_d;
   logic [4:0]       col_q, col_d;
   logic [1:0]       func_q, func_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             flipx_q, flipx_d;
   logic             flipy_q, flipy_d;
   logic [1:0]       score_q, score_d;
   logic             terr_q, terr_d;

   logic signed [10:0] xs, ys, rs, px, py;
   logic [10:0]        rowOff, rowIdx, colIdx;
   logic               outOfField;
   logic               moreAfterMiss, moreAfterHit;

   // Probe point for the current probe and its brick address. Arithmetic is
   // 11-bit signed so a probe left of x=0 shows up as negative. The address
   // bits are only meaningful when outOfField is low.
   always_comb begin
      xs = $signed({1'b0, x_q});
      ys = $signed({1'b0, y_q});
      rs = $signed({5'b0, r_q});
      px = xs;
      py = ys;
      case (probe_q)
         2'd0: py = dyn_q ? ys - rs : ys + rs;
         2'd1: px = dxn_q ? xs - rs : xs + rs;
         default: begin
            px = dxn_q ? xs - rs : xs + rs;
            py = dyn_q ? ys - rs : ys + rs;
         end
      endcase
      rowOff     = py - FieldTop;
      rowIdx     = rowOff >> BLOCK_H_LOG2;
      colIdx     = px >> BLOCK_W_LOG2;
      outOfField = px[10] || (py < FieldTop) ||
                   (rowIdx >= RowLimit) || (colIdx >= ColLimit);
   end

   // Whether another probe follows the current one. After a hit only probe 0
   // has a successor; after a miss, the diagonal probe follows probe 1 when
   // it is built in and nothing has been hit yet this request.
   always_comb begin
      moreAfterHit  = (probe_q == 2'd0);
      moreAfterMiss = (probe_q == 2'd0) ||
                      (CornerEn && (probe_q == 2'd1) && (score_q == 2'd0));
   end

   // Next-state and output logic. Every output is registered, so each
   // transition prepares the value that should appear after the next edge:
   // bm_enable rises with entry into READ/WRITE and falls on the edge that
   // samples bm_ready, which forces at least one idle cycle between accesses.
   always_comb begin
      state_d  = state_q;
      probe_d  = probe_q;
      x_d      = x_q;
      y_d      = y_q;
      r_d      = r_q;
      dxn_d    = dxn_q;
      dyn_d    = dyn_q;
      blk_d    = blk_q;
      wait_d   = wait_q;
      enable_d = enable_q;
      row_d    = row_q;
      col_d    = col_q;
      func_d   = func_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      flipx_d  = flipx_q;
      flipy_d  = flipy_q;
      score_d  = score_q;
      terr_d   = terr_q;

      case (state_q)
         IDLE: begin
            if (req) begin
               x_d     = ball_x;
               y_d     = ball_y;
               r_d     = radius;
               dxn_d   = dx_neg;
               dyn_d   = dy_neg;
               flipx_d = 1'b0;
               flipy_d = 1'b0;
               score_d = 2'd0;
               busy_d  = 1'b1;
               probe_d = 2'd0;
               state_d = CALC;
            end
         end

         CALC: begin
            if (outOfField) begin
               if (moreAfterMiss) begin
                  probe_d = probe_q + 2'd1;
               end else begin
                  state_d = DONE;
               end
            end else begin
               row_d    = rowIdx[4:0];
               col_d    = colIdx[4:0];
               enable_d = 1'b1;
               func_d   = FuncRead;
               wait_d   = '0;
               state_d  = READ;
            end
         end

         READ: begin
            if (bm.bm_ready) begin
               blk_d    = bm.bm_block;
               enable_d = 1'b0;
               state_d  = EVAL;
            end else if (wait_q == WaitLast) begin
               enable_d = 1'b0;
               terr_d   = 1'b1;
               state_d  = DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         EVAL: begin
            if (blk_q == 4'd0) begin
               if (moreAfterMiss) begin
                  probe_d = probe_q + 2'd1;
                  state_d = CALC;
               end else begin
                  state_d = DONE;
               end
            end else begin
               enable_d = 1'b1;
               func_d   = FuncHit;
               wait_d   = '0;
               state_d  = WRITE;
            end
         end

         WRITE: begin
            if (bm.bm_ready) begin
               enable_d = 1'b0;
               func_d   = FuncRead;
               score_d  = score_q + 2'd1;
               case (probe_q)
                  2'd0: flipy_d = 1'b1;
                  2'd1: flipx_d = 1'b1;
                  default: begin
                     flipx_d = 1'b1;
                     flipy_d = 1'b1;
                  end
               endcase
               if (moreAfterHit) begin
                  probe_d = probe_q + 2'd1;
                  state_d = CALC;
               end else begin
                  state_d = DONE;
               end
            end else if (wait_q == WaitLast) begin
               enable_d = 1'b0;
               func_d   = FuncRead;
               terr_d   = 1'b1;
               state_d  = DONE;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end

         DONE: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and output registers. Reset drops bm_enable on the next edge and
   // abandons any access in flight; nothing is retried afterwards.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         probe_q  <= 2'd0;
         x_q      <= '0;
         y_q      <= '0;
         r_q      <= '0;
         dxn_q    <= 1'b0;
         dyn_q    <= 1'b0;
         blk_q    <= '0;
         wait_q   <= '0;
         enable_q <= 1'b0;
         row_q    <= '0;
         col_q    <= '0;
         func_q   <= FuncRead;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         flipx_q  <= 1'b0;
         flipy_q  <= 1'b0;
         score_q  <= 2'd0;
         terr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         probe_q  <= probe_d;
         x_q      <= x_d;
         y_q      <= y_d;
         r_q      <= r_d;
         dxn_q    <= dxn_d;
         dyn_q    <= dyn_d;
         blk_q    <= blk_d;
         wait_q   <= wait_d;
         enable_q <= enable_d;
         row_q    <= row_d;
         col_q    <= col_d;
         func_q   <= func_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         flipx_q  <= flipx_d;
         flipy_q  <= flipy_d;
         score_q  <= score_d;
         terr_q   <= terr_d;
      end
   end

   assign bm.bm_enable = enable_q;
   assign bm.bm_row    = row_q;
   assign bm.bm_col    = col_q;
   assign bm.bm_func   = func_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign flip_x       = flipx_q;
   assign flip_y       = flipy_q;
   assign score_inc    = score_q;
   assign timeout_err  = terr_q;

endmodule

// File: tb/tb_block_collider.sv
// tb_block_collider
// Bench for block_collider. A behavioural block_memory (strength array with
// saturating decrement on hits, ready level set by the bench) sits on the
// slave side of the interface. Each table record holds a ball, up to two
// preloaded bricks and the expected memory accesses, flags, score and done
// cycle. Expectations are queued when a request is driven and popped as the
// DUT performs accesses and pulses done.
// Cycle numbering: cycle 0 is the edge that samples req; cycle k is observed
// on the falling edge after rising edge k.
module tb_block_collider;

   typedef struct {
      logic [9:0]       x;
      logic [9:0]       y;
      logic [5:0]       r;
      logic             dxn;
      logic             dyn;
      logic [4:0]       aRow, aCol;
      logic [3:0]       aVal;
      logic [4:0]       bRow, bCol;
      logic [3:0]       bVal;
      logic             fx, fy;
      logic [1:0]       score;
      int               doneCyc;
      int               nAcc;
      logic [3:0][11:0] accList;
   } vec_t;

   typedef struct {
      logic       fx;
      logic       fy;
      logic [1:0] score;
      int         doneCyc;
   } res_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       req;
   logic [9:0] ballX, ballY;
   logic [5:0] radius;
   logic       dxNeg, dyNeg;
   logic       busy, done, flipX, flipY;
   logic [1:0] scoreInc;
   logic       timeoutErr;
   logic       readyHigh;
   logic [3:0] mem [0:31][0:31];

   int          total = 0;
   int          bad = 0;
   res_t        resQ[$];
   logic [11:0] accQ[$];
   vec_t        vecs[$];

   block_collider_if bus();

   assign bus.bm_ready = readyHigh;
   assign bus.bm_block = mem[bus.bm_row][bus.bm_col];

   block_collider dut (
      .clock       (clock),
      .reset       (reset),
      .req         (req),
      .ball_x      (ballX),
      .ball_y      (ballY),
      .radius      (radius),
      .dx_neg      (dxNeg),
      .dy_neg      (dyNeg),
      .bm          (bus),
      .busy        (busy),
      .done        (done),
      .flip_x      (flipX),
      .flip_y      (flipY),
      .score_inc   (scoreInc),
      .timeout_err (timeoutErr)
   );

   always #5 clock = ~clock;

   function automatic logic [11:0] acc(input int row, input int col, input int func);
      return {5'(row), 5'(col), 2'(func)};
   endfunction

   function automatic vec_t mkVec(input int x, input int y, input int r,
                                  input int dxn, input int dyn,
                                  input int aR, input int aC, input int aV,
                                  input int bR, input int bC, input int bV,
                                  input int fx, input int fy, input int sc,
                                  input int dc, input int n,
                                  input logic [11:0] a0, input logic [11:0] a1,
                                  input logic [11:0] a2, input logic [11:0] a3);
      vec_t v;
      v.x = 10'(x);  v.y = 10'(y);  v.r = 6'(r);
      v.dxn = 1'(dxn);  v.dyn = 1'(dyn);
      v.aRow = 5'(aR);  v.aCol = 5'(aC);  v.aVal = 4'(aV);
      v.bRow = 5'(bR);  v.bCol = 5'(bC);  v.bVal = 4'(bV);
      v.fx = 1'(fx);  v.fy = 1'(fy);  v.score = 2'(sc);
      v.doneCyc = dc;  v.nAcc = n;
      v.accList[0] = a0;  v.accList[1] = a1;
      v.accList[2] = a2;  v.accList[3] = a3;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic memClear();
      for (int i = 0; i < 32; i++)
         for (int j = 0; j < 32; j++)
            mem[i][j] = 4'd0;
   endtask

   // Memory side of one falling-edge sample: a request with ready high
   // completes on the coming rising edge, so it is scored here and a hit
   // decrements the model strength (saturating at zero).
   task automatic observe();
      logic [11:0] got;
      logic [11:0] want;
      if (bus.bm_enable && bus.bm_ready) begin
         got = {bus.bm_row, bus.bm_col, bus.bm_func};
         if (accQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected access: got=%0h want=none", got);
         end else begin
            want = accQ.pop_front();
            check("access", got, want);
         end
         if (bus.bm_func == 2'b01 && mem[bus.bm_row][bus.bm_col] != 4'd0)
            mem[bus.bm_row][bus.bm_col] = mem[bus.bm_row][bus.bm_col] - 4'd1;
      end
   endtask

   task automatic checkOutput(input int cyc);
      res_t e;
      if (resQ.size() == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL spurious done: got=cycle %0d want=none", cyc);
      end else begin
         e = resQ.pop_front();
         check("flags fx/fy/score", {flipX, flipY, scoreInc}, {e.fx, e.fy, e.score});
         check("done cycle", cyc, e.doneCyc);
         check("busy at done", busy, 0);
      end
   endtask

   task automatic applyStimulus(input vec_t v, input logic readyLvl, output int enCnt);
      int cyc;
      bit seen;
      res_t e;
      memClear();
      if (v.aVal != 4'd0) mem[v.aRow][v.aCol] = v.aVal;
      if (v.bVal != 4'd0) mem[v.bRow][v.bCol] = v.bVal;
      for (int i = 0; i < v.nAcc; i++) accQ.push_back(v.accList[i]);
      e.fx = v.fx;  e.fy = v.fy;  e.score = v.score;  e.doneCyc = v.doneCyc;
      resQ.push_back(e);

      @(negedge clock);
      readyHigh = readyLvl;
      ballX = v.x;  ballY = v.y;  radius = v.r;
      dxNeg = v.dxn;  dyNeg = v.dyn;
      req = 1'b1;
      @(posedge clock);
      cyc = 0;
      seen = 1'b0;
      enCnt = 0;
      while (!seen && cyc < 600) begin
         @(negedge clock);
         req = 1'b0;
         if (bus.bm_enable) enCnt++;
         observe();
         if (done) begin
            checkOutput(cyc);
            seen = 1'b1;
         end else begin
            @(posedge clock);
            cyc++;
         end
      end
      if (!seen) begin
         total++;
         bad++;
         $display("[TB] FAIL no done: got=none after %0d cycles want=cycle %0d", cyc, v.doneCyc);
         resQ.delete();
      end
      check("leftover accesses", accQ.size(), 0);
      accQ.delete();
   endtask

   initial begin
      int enCnt;
      vec_t tv;

      reset = 1'b1;  req = 1'b0;
      ballX = '0;  ballY = '0;  radius = '0;  dxNeg = 1'b0;  dyNeg = 1'b0;
      readyHigh = 1'b1;
      memClear();
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("reset busy", busy, 0);
      check("reset done", done, 0);
      check("reset bm_enable", bus.bm_enable, 0);
      check("reset flags", {flipX, flipY, scoreInc}, 0);
      check("reset timeout_err", timeoutErr, 0);
      reset = 1'b0;

`ifdef BLOCK_COLLIDER_CORNER_EN
      // both axis probes miss; diagonal also lands on empty (3,3)
      vecs.push_back(mkVec(90, 94, 6, 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 0, 10, 3,
                           acc(3, 2, 0), acc(3, 3, 0), acc(3, 3, 0), 12'h0));
      // diagonal hit on (2,3) flips both axes
      vecs.push_back(mkVec(94, 90, 4, 0, 1, 2, 3, 1, 0, 0, 0, 1, 1, 1, 11, 4,
                           acc(2, 2, 0), acc(3, 3, 0), acc(2, 3, 0), acc(2, 3, 1)));
      // probe 0 hit suppresses the diagonal probe
      vecs.push_back(mkVec(100, 90, 4, 0, 1, 2, 3, 2, 0, 0, 0, 0, 1, 1, 8, 3,
                           acc(2, 3, 0), acc(2, 3, 1), acc(3, 3, 0), 12'h0));
      // all three probes out of field
      vecs.push_back(mkVec(5, 20, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4, 0,
                           12'h0, 12'h0, 12'h0, 12'h0));
`else
      // empty field, two reads
      vecs.push_back(mkVec(100, 90, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 2,
                           acc(2, 3, 0), acc(3, 3, 0), 12'h0, 12'h0));
      // vertical hit
      vecs.push_back(mkVec(100, 90, 4, 0, 1, 2, 3, 2, 0, 0, 0, 0, 1, 1, 8, 3,
                           acc(2, 3, 0), acc(2, 3, 1), acc(3, 3, 0), 12'h0));
      // both probes out of field
      vecs.push_back(mkVec(5, 20, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                           12'h0, 12'h0, 12'h0, 12'h0));
      // horizontal hit
      vecs.push_back(mkVec(100, 90, 4, 0, 1, 3, 3, 1, 0, 0, 0, 1, 0, 1, 8, 3,
                           acc(2, 3, 0), acc(3, 3, 0), acc(3, 3, 1), 12'h0));
      // both axes hit different bricks
      vecs.push_back(mkVec(100, 90, 4, 0, 1, 2, 3, 1, 3, 3, 3, 1, 1, 2, 9, 4,
                           acc(2, 3, 0), acc(2, 3, 1), acc(3, 3, 0), acc(3, 3, 1)));
      // same brick under both probes, strength 2, hit twice
      vecs.push_back(mkVec(100, 88, 4, 0, 0, 3, 3, 2, 0, 0, 0, 1, 1, 2, 9, 4,
                           acc(3, 3, 0), acc(3, 3, 1), acc(3, 3, 0), acc(3, 3, 1)));
      // horizontal probe left of x=0 is skipped
      vecs.push_back(mkVec(10, 90, 20, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1,
                           acc(1, 0, 0), 12'h0, 12'h0, 12'h0));
      // probes just past the last row and last column
      vecs.push_back(mkVec(639, 228, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0,
                           12'h0, 12'h0, 12'h0, 12'h0));
      // last row/column cell is still in field
      vecs.push_back(mkVec(636, 227, 3, 0, 0, 11, 19, 1, 0, 0, 0, 0, 1, 1, 8, 3,
                           acc(11, 19, 0), acc(11, 19, 1), acc(11, 19, 0), 12'h0));
      // probe exactly on the top edge of row 0
      vecs.push_back(mkVec(64, 44, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 2,
                           acc(0, 2, 0), acc(0, 2, 0), 12'h0, 12'h0));
`endif

      foreach (vecs[i]) applyStimulus(vecs[i], 1'b1, enCnt);

      // memory never answers: enable held 255 cycles, then timeout and done
      tv = mkVec(100, 90, 4, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 257, 0,
                 12'h0, 12'h0, 12'h0, 12'h0);
      applyStimulus(tv, 1'b0, enCnt);
      check("timeout enable cycles", enCnt, 255);
      check("timeout_err set", timeoutErr, 1);
      check("timeout bm_enable dropped", bus.bm_enable, 0);

      // second req during a request is ignored; reset in WRITE aborts it
      memClear();
      mem[2][3] = 4'd2;
      readyHigh = 1'b1;
      @(negedge clock);
      ballX = 10'd100;  ballY = 10'd90;  radius = 6'd4;  dxNeg = 1'b0;  dyNeg = 1'b1;
      req = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      req = 1'b1;
      check("busy-test read", {bus.bm_row, bus.bm_col, bus.bm_func, bus.bm_enable},
            {5'd2, 5'd3, 2'b00, 1'b1});
      @(posedge clock);
      @(negedge clock);
      req = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("busy-test write", {bus.bm_enable, bus.bm_row, bus.bm_col, bus.bm_func, busy},
            {1'b1, 5'd2, 5'd3, 2'b01, 1'b1});
      readyHigh = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      check("reset-in-write bm_enable", bus.bm_enable, 0);
      check("reset-in-write busy", busy, 0);
      check("reset-in-write timeout_err", timeoutErr, 0);
      check("reset-in-write done", done, 0);
      reset = 1'b0;
      repeat (4) @(negedge clock);
      check("no queued request", {busy, bus.bm_enable}, 2'b00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
